// File: rtl/bitwise_reduce_nbit.sv
// Streaming bitwise reducer: folds LEN operands of W bits with OR/AND/XOR/NOR
// and presents the result on a registered valid/ready port.
module bitwise_reduce_nbit #(
  parameter int W     = 32,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_OUT
  } state_t;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_out;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic [1:0]       r_op;

  logic             w_fire;
  logic             w_last;
  logic [W-1:0]     w_acc_nx;
  logic [W-1:0]     w_post_nx;
  logic [W-1:0]     w_ident;
  logic [W-1:0]     w_empty;

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out;

  assign w_fire = in_valid & in_ready;
  assign w_last = (r_cnt == (r_len - ONE));

  // NOR folds as OR; the inversion is applied once on the way out
  always_comb begin
    w_acc_nx = r_acc;
    unique case (r_op)
      OP_OR:   w_acc_nx = r_acc | in_data;
      OP_AND:  w_acc_nx = r_acc & in_data;
      OP_XOR:  w_acc_nx = r_acc ^ in_data;
      OP_NOR:  w_acc_nx = r_acc | in_data;
      default: w_acc_nx = r_acc;
    endcase
  end

  assign w_post_nx = (r_op == OP_NOR) ? ~w_acc_nx : w_acc_nx;
  assign w_ident   = (op == OP_AND) ? '1 : '0;
  assign w_empty   = (op == OP_NOR) ? ~w_ident : w_ident;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_op    <= OP_OR;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op;
            r_len <= len;
            r_cnt <= '0;
            r_acc <= w_ident;
            if (len == '0) begin
              r_out   <= w_empty;
              r_state <= S_OUT;
            end else begin
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_fire) begin
            r_acc <= w_acc_nx;
            r_cnt <= r_cnt + ONE;
            if (w_last) begin
              r_out   <= w_post_nx;
              r_state <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_reduce_nbit.sv
// Directed table-driven bench for bitwise_reduce_nbit.
// Covers each op, empty jobs, backpressure, stalls, max length and reset abort.
module tb_bitwise_reduce_nbit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  bitwise_reduce_nbit #(.W(32), .LEN_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [4:0]       len;
    logic [3:0][31:0] d;
    logic [31:0]      exp;
    int               gaps;
    int               hold;
    string            nm;
  } vec_t;

  vec_t        tv[10];
  logic [31:0] beats[31];
  int          total;
  int          bad;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_job(input logic [1:0] o, input logic [4:0] l,
                         input logic [31:0] exp, input int gaps,
                         input int hold, input string nm);
    int to;
    int g;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    op    = ~o;
    len   = 5'd9;
    for (int b = 0; b < int'(l); b++) begin
      if (gaps != 0) begin
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_data  = 32'hFFFF_FFFF;
          start    = 1'b1;
          @(negedge clk);
          start    = 1'b0;
        end
      end
      in_valid = 1'b1;
      in_data  = beats[b];
      to = 0;
      while (!in_ready && to < 10) begin
        @(negedge clk);
        to++;
      end
      if (!in_ready) begin
        chk({nm, "/in_ready_timeout"}, 32'(in_ready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 32'h0;
    chk({nm, "/latency_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "/data"}, out_data, exp);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      @(negedge clk);
      chk({nm, "/hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "/hold_data"}, out_data, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    chk({nm, "/busy_after"}, 32'(busy), 32'd0);
    chk({nm, "/valid_after"}, 32'(out_valid), 32'd0);
    to = 0;
    out_ready = 1'b1;
    while (busy && to < 40) begin
      @(negedge clk);
      to++;
    end
    out_ready = 1'b0;
    if (busy) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    len       = 5'd0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;

    tv[0] = '{2'b00, 5'd3,
              {32'h0, 32'h8000_0000, 32'h0000_0F00, 32'h0000_000F},
              32'h8000_0F0F, 0, 0, "or3"};
    tv[1] = '{2'b01, 5'd2,
              {32'h0, 32'h0, 32'h0F0F_0F0F, 32'hFFFF_00FF},
              32'h0F0F_000F, 0, 5, "and2"};
    tv[2] = '{2'b11, 5'd2,
              {32'h0, 32'h0, 32'h0000_0002, 32'h0000_0001},
              32'hFFFF_FFFC, 0, 0, "nor2"};
    tv[3] = '{2'b10, 5'd4,
              {32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5},
              32'h0000_0000, 0, 0, "xor4"};
    tv[4] = '{2'b01, 5'd0, {32'h0, 32'h0, 32'h0, 32'h0},
              32'hFFFF_FFFF, 0, 0, "and0"};
    tv[5] = '{2'b00, 5'd0, {32'h0, 32'h0, 32'h0, 32'h0},
              32'h0000_0000, 0, 0, "or0"};
    tv[6] = '{2'b11, 5'd0, {32'h0, 32'h0, 32'h0, 32'h0},
              32'hFFFF_FFFF, 0, 0, "nor0"};
    tv[7] = '{2'b10, 5'd3,
              {32'h0, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'h1234_5678},
              32'hE2C4_5977, 1, 5, "xor3_stall"};
    tv[8] = '{2'b01, 5'd1, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF},
              32'hDEAD_BEEF, 0, 0, "and1"};
    tv[9] = '{2'b11, 5'd4,
              {32'h0000_00F0, 32'h0000_0F00, 32'h0000_F000, 32'h000F_0000},
              32'hFFF0_000F, 1, 2, "nor4_stall"};

    repeat (2) @(negedge clk);
    chk("rst/in_ready", 32'(in_ready), 32'd0);
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/out_data", out_data, 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < 4; b++) beats[b] = tv[i].d[b];
      run_job(tv[i].op, tv[i].len, tv[i].exp, tv[i].gaps, tv[i].hold,
              tv[i].nm);
    end

    for (int k = 0; k < 31; k++) beats[k] = 32'h1 << k;
    run_job(2'b00, 5'd31, 32'h7FFF_FFFF, 0, 2, "max31");
    run_job(2'b00, 5'd31, 32'h7FFF_FFFF, 1, 0, "max31_stall");

    // abort after two accepted beats; the follow-up job must see no residue
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    len   = 5'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_0000;
    @(negedge clk);
    in_data  = 32'h0000_00FF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort/busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort/in_ready", 32'(in_ready), 32'd0);
    chk("abort/out_valid", 32'(out_valid), 32'd0);
    chk("abort/out_data", out_data, 32'd0);
    chk("abort/busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beats[0] = 32'h0000_0003;
    beats[1] = 32'h0000_0005;
    run_job(2'b10, 5'd2, 32'h0000_0006, 0, 0, "post_abort_xor");
    beats[0] = 32'h0000_0010;
    run_job(2'b00, 5'd1, 32'h0000_0010, 0, 0, "post_abort_or");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
